// File: rtl/delta_lif_array.sv
// Array of independent leaky integrate-and-fire neurons with delta-spike encoding.
// Each valid step leaks, integrates and thresholds every channel; outputs are registered.
module delta_lif_array #(
  parameter int WIDTH      = 8,
  parameter int N_CH       = 4,
  parameter int V_TH       = 200,
  parameter int DELTA_TH   = 10,
  parameter int BETA_SHIFT = 1,
  parameter int REFRAC     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N_CH*WIDTH-1:0]     in_current,
  output logic                      out_valid,
  output logic [N_CH-1:0]           fire,
  output logic [N_CH-1:0]           dspike_pos,
  output logic [N_CH-1:0]           dspike_neg,
  output logic [N_CH*(WIDTH+1)-1:0] delta_out,
  output logic [N_CH*WIDTH-1:0]     state_out
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [WIDTH:0]         VTH_EXT   = (WIDTH+1)'(V_TH);
  localparam logic [RW-1:0]          REFRAC_LD = RW'(REFRAC);
  localparam logic signed [31:0]     DTH_POS   = 32'(DELTA_TH);
  localparam logic signed [31:0]     DTH_NEG   = -32'(DELTA_TH);

  logic [N_CH-1:0][WIDTH-1:0] cur;
  logic [N_CH-1:0][WIDTH-1:0] v_q, v_d;
  logic [N_CH-1:0][RW-1:0]    r_q, r_d;
  logic                       out_valid_q, out_valid_d;
  logic [N_CH-1:0]            fire_q, fire_d;
  logic [N_CH-1:0]            pos_q, pos_d;
  logic [N_CH-1:0]            neg_q, neg_d;
  logic [N_CH-1:0][WIDTH:0]   delta_q, delta_d;

  logic [WIDTH-1:0]   leak;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   v_new;
  logic [WIDTH:0]     d;
  logic signed [31:0] d_ext;

  assign cur = in_current;

  always_comb begin
    v_d         = v_q;
    r_d         = r_q;
    out_valid_d = in_valid;
    fire_d      = '0;
    pos_d       = '0;
    neg_d       = '0;
    delta_d     = '0;
    leak        = '0;
    sum         = '0;
    v_new       = '0;
    d           = '0;
    d_ext       = '0;
    if (in_valid) begin
      for (int c = 0; c < N_CH; c++) begin
        leak  = v_q[c] - (v_q[c] >> BETA_SHIFT);
        // Sum kept one bit wider so an overflowing integration still crosses threshold.
        sum   = {1'b0, leak} + {1'b0, cur[c]};
        v_new = '0;
        if (r_q[c] != '0) begin
          r_d[c] = r_q[c] - RW'(1);
        end else if (sum >= VTH_EXT) begin
          r_d[c]    = REFRAC_LD;
          fire_d[c] = 1'b1;
        end else begin
          v_new = sum[WIDTH-1:0];
        end
        d        = {1'b0, v_new} - {1'b0, v_q[c]};
        d_ext    = {{(31-WIDTH){d[WIDTH]}}, d};
        pos_d[c] = (d_ext >= DTH_POS);
        neg_d[c] = (d_ext <= DTH_NEG);
        if (pos_d[c] || neg_d[c]) begin
          delta_d[c] = d;
        end
        v_d[c] = v_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      fire_q      <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      delta_q     <= '0;
    end else begin
      v_q         <= v_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      fire_q      <= fire_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      delta_q     <= delta_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign fire       = fire_q;
  assign dspike_pos = pos_q;
  assign dspike_neg = neg_q;
  assign delta_out  = delta_q;
  assign state_out  = v_q;

endmodule

// File: tb/tb_delta_lif_array.sv
// Bench for delta_lif_array: directed scenarios plus random steps, all checked
// against an integer-arithmetic neuron model.
module tb_delta_lif_array;
  localparam int W    = 8;
  localparam int N    = 4;
  localparam int VTH  = 200;
  localparam int DTH  = 10;
  localparam int BS   = 1;
  localparam int RFR  = 3;
  localparam int DW   = N * (W + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [N*W-1:0]  in_current;
  logic            out_valid;
  logic [N-1:0]    fire, dspike_pos, dspike_neg;
  logic [DW-1:0]   delta_out;
  logic [N*W-1:0]  state_out;

  int checks = 0;
  int failures = 0;

  int mv[N];
  int mr[N];

  delta_lif_array #(
    .WIDTH(W), .N_CH(N), .V_TH(VTH), .DELTA_TH(DTH), .BETA_SHIFT(BS), .REFRAC(RFR)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
    .out_valid(out_valid), .fire(fire), .dspike_pos(dspike_pos),
    .dspike_neg(dspike_neg), .delta_out(delta_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic step(input logic r, input logic v, input logic [N*W-1:0] cur);
    logic          e_ov;
    logic [N-1:0]  e_f, e_p, e_n;
    logic [DW-1:0] e_d;
    logic [N*W-1:0] e_s;
    int vl, s, nv, d;
    rst = r; in_valid = v; in_current = cur;
    e_ov = 1'b0; e_f = '0; e_p = '0; e_n = '0; e_d = '0;
    if (r) begin
      for (int c = 0; c < N; c++) begin mv[c] = 0; mr[c] = 0; end
    end else if (v) begin
      e_ov = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (mr[c] > 0) begin
          nv = 0;
          mr[c] = mr[c] - 1;
        end else begin
          vl = mv[c] - (mv[c] / (1 << BS));
          s  = vl + int'(cur[c*W +: W]);
          if (s >= VTH) begin
            nv = 0; mr[c] = RFR; e_f[c] = 1'b1;
          end else begin
            nv = s;
          end
        end
        d = nv - mv[c];
        e_p[c] = (d >= DTH);
        e_n[c] = (d <= -DTH);
        if (e_p[c] || e_n[c]) e_d[c*(W+1) +: W+1] = (W+1)'(d);
        mv[c] = nv;
      end
    end
    for (int c = 0; c < N; c++) e_s[c*W +: W] = W'(mv[c]);
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(e_ov));
    check("fire", 64'(fire), 64'(e_f));
    check("dspike_pos", 64'(dspike_pos), 64'(e_p));
    check("dspike_neg", 64'(dspike_neg), 64'(e_n));
    check("delta_out", 64'(delta_out), 64'(e_d));
    check("state_out", 64'(state_out), 64'(e_s));
  endtask

  function automatic logic [N*W-1:0] ch0(input int i);
    logic [N*W-1:0] x;
    x = '0;
    x[W-1:0] = W'(i);
    return x;
  endfunction

  initial begin
    logic [N*W-1:0] cur;
    rst = 1'b1; in_valid = 1'b0; in_current = '0;
    for (int c = 0; c < N; c++) begin mv[c] = 0; mr[c] = 0; end
    @(posedge clk); #1;

    // Reset held with a live all-ones step, then release idle.
    step(1'b1, 1'b1, '1);
    step(1'b1, 1'b1, '1);
    check("rst_state", 64'(state_out), 64'd0);
    step(1'b0, 1'b0, '1);
    check("rst_release_ov", 64'(out_valid), 64'd0);

    // Delta encoding 20, 20, 0.
    step(1'b0, 1'b1, ch0(20));
    check("enc1_state", 64'(state_out[W-1:0]), 64'd20);
    check("enc1_delta", 64'(delta_out[W:0]), 64'd20);
    step(1'b0, 1'b1, ch0(20));
    check("enc2_state", 64'(state_out[W-1:0]), 64'd30);
    check("enc2_delta", 64'(delta_out[W:0]), 64'd10);
    step(1'b0, 1'b1, ch0(0));
    check("enc3_state", 64'(state_out[W-1:0]), 64'd15);
    check("enc3_delta", 64'(delta_out[W:0]), 64'h1F1);
    check("enc3_neg", 64'(dspike_neg[0]), 64'd1);

    // Sub-threshold delta from v=30.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, ch0(30));
    step(1'b0, 1'b1, ch0(6));
    check("sub_state", 64'(state_out[W-1:0]), 64'd21);
    check("sub_delta", 64'(delta_out[W:0]), 64'd0);

    // Fire and refractory from v=150.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, ch0(150));
    step(1'b0, 1'b1, ch0(130));
    check("fire_hit", 64'(fire[0]), 64'd1);
    check("fire_delta", 64'(delta_out[W:0]), 64'h16A);
    for (int k = 0; k < RFR; k++) step(1'b0, 1'b1, ch0(255));
    check("refrac_state", 64'(state_out[W-1:0]), 64'd0);
    step(1'b0, 1'b1, ch0(255));
    check("refire", 64'(fire[0]), 64'd1);

    // Gaps and channel independence.
    step(1'b1, 1'b0, '0);
    cur = '0; cur[2*W-1:W] = W'(50);
    step(1'b0, 1'b1, cur);
    step(1'b0, 1'b0, cur);
    check("gap_ov", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, cur);
    step(1'b0, 1'b1, cur);
    check("gap_ch1", 64'(state_out[2*W-1:W]), 64'd75);
    check("gap_ch2", 64'(state_out[3*W-1:2*W]), 64'd0);

    // Reset in the middle of refractory.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, ch0(250));
    step(1'b1, 1'b1, ch0(0));
    step(1'b0, 1'b1, ch0(40));
    check("mid_rst_state", 64'(state_out[W-1:0]), 64'd40);
    check("mid_rst_delta", 64'(delta_out[W:0]), 64'd40);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        cur[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(150, 255))
                                                     : W'($urandom_range(0, 80));
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delta_lif_array.md
DELTA_LIF_ARRAY -- requirements
Module: delta_lif_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8: membrane/current width in bits, unsigned.
REQ-002 SHALL have parameter N_CH, default 4: number of independent neuron channels.
REQ-003 SHALL have parameter V_TH, default 200: fire threshold, 1..2^WIDTH-1.
REQ-004 SHALL have parameter DELTA_TH, default 10: delta-spike magnitude threshold, ≥1.
REQ-005 SHALL have parameter BETA_SHIFT, default 1: leak shift, 1..WIDTH-1.
REQ-006 SHALL have parameter REFRAC, default 3: refractory length in valid steps, ≥0.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-009 SHALL have port in_valid  input  1  time-step strobe; one integration step per cycle it is high.
REQ-010 SHALL have port in_current  input  N_CH*WIDTH  unsigned input current; channel c in bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  1  high for exactly one cycle per accepted step.
REQ-012 SHALL have port fire  output  N_CH  per-channel threshold-crossing spike.
REQ-013 SHALL have port dspike_pos  output  N_CH  per-channel positive delta spike.
REQ-014 SHALL have port dspike_neg  output  N_CH  per-channel negative delta spike.
REQ-015 SHALL have port delta_out  output  N_CH*(WIDTH+1)  signed two's-complement membrane delta, channel c in [c*(WIDTH+1) +: WIDTH+1].
REQ-016 SHALL have port state_out  output  N_CH*WIDTH  current membrane value per channel.

Function
REQ-017 SHALL keep per channel a WIDTH-bit membrane v and a refractory counter r of width clog2(REFRAC+1) (min 1 bit).
REQ-018 On a cycle with in_valid=1 and r>0: v_next=0, r decrements by 1, fire=0, in_current for that channel ignored.
REQ-019 On a cycle with in_valid=1 and r=0: leak v_l = v - (v >> BETA_SHIFT); sum = v_l + I computed in WIDTH+1 bits, no truncation before compare.
REQ-020 If sum ≥ V_TH: fire=1, v_next=0, r=REFRAC; else fire=0, v_next=sum[WIDTH-1:0].
REQ-021 Delta per channel: d = v_next - v (old value), signed WIDTH+1 bits.
REQ-022 dspike_pos=1 iff d ≥ DELTA_TH; dspike_neg=1 iff d ≤ -DELTA_TH; never both.
REQ-023 delta_out = d when dspike_pos or dspike_neg, else 0.
REQ-024 Latency 1: all outputs registered, updated on the edge that samples in_valid=1; out_valid high in the following cycle only.
REQ-025 On a cycle with in_valid=0: v and r hold; next cycle out_valid=0, fire=0, dspike_pos=0, dspike_neg=0, delta_out=0; state_out holds.
REQ-026 Channels SHALL be fully independent; no cross-channel arithmetic or shared state.
REQ-027 Back-to-back in_valid every cycle SHALL be supported with no stall; no ready signal exists.
REQ-028 REFRAC=0: a fired channel integrates again on the very next valid step.

Reset
REQ-029 When rst=1 at a clock edge: all v=0, all r=0, out_valid=0, fire=0, dspike_pos=0, dspike_neg=0, delta_out=0, state_out=0.
REQ-030 rst SHALL take priority over in_valid in the same cycle; the step is discarded, not replayed.
REQ-031 Reset mid-refractory SHALL clear r; the first valid step after reset integrates normally.

Verification (defaults, channel 0 unless stated)
REQ-032 Reset: assert rst 2 cycles with in_valid=1, in_current=all 0xFF -> all outputs 0, out_valid=0 throughout and on the cycle after release.
REQ-033 Delta encode: steps I=20,20,0 from v=0 -> state_out 20,30,15; dspike_pos,pos,neg; delta_out 20, 10, -15 (0x1F1); fire=0.
REQ-034 Sub-threshold delta: v=30, step I=6 -> v=21, d=-9, no dspike, delta_out=0, out_valid=1.
REQ-035 Fire + refractory: v=150, step I=130 -> sum 205, fire=1, v=0, dspike_neg, delta_out=-150; next 3 steps with I=255 -> v=0, fire=0; 4th step I=255 -> sum 255 ≥ 200, fire=1.
REQ-036 Gaps/independence: in_valid pattern 1,0,0,1 with ch1 I=50, ch2 I=0 -> out_valid 2 pulses only; ch1 v 50 then 75, ch2 silent; outputs 0 on idle cycles.
REQ-037 Reset mid-refractory: fire ch0, assert rst on next cycle, then step I=40 -> v=40, fire=0, dspike_pos, delta_out=40.
